// File: rtl/compliment2_iter.sv
// Multi-cycle two's-complement unit: pass / negate / abs / sign-magnitude conversion,
// processing CHUNK bits per cycle with a registered carry between slices.
module compliment2_iter #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NCH - 1);
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH - 1){1'b0}}};

  localparam logic [1:0] ModePass  = 2'b00;
  localparam logic [1:0] ModeNeg   = 2'b01;
  localparam logic [1:0] ModeAbs   = 2'b10;
  localparam logic [1:0] ModeSm2tc = 2'b11;

  if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("compliment2_iter: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [IdxW-1:0]   idx_q;
  logic              inv_q, carry_q, ovf_q, out_valid_q;

  logic [WIDTH-1:0]  op_in;
  logic              neg_in, ovf_in;
  logic [CHUNK:0]    sum;

  // Accept-time decode; for every mode the invert flag and initial carry coincide.
  always_comb begin
    op_in  = in_data;
    neg_in = 1'b0;
    unique case (mode)
      ModePass:  neg_in = 1'b0;
      ModeNeg:   neg_in = 1'b1;
      ModeAbs:   neg_in = in_data[WIDTH-1];
      ModeSm2tc: begin
        op_in[WIDTH-1] = 1'b0;
        neg_in         = in_data[WIDTH-1];
      end
      default:   neg_in = 1'b0;
    endcase
    ovf_in = ((mode == ModeNeg) || (mode == ModeAbs)) && (in_data == MinVal);
  end

  always_comb begin
    sum    = {1'b0, data_q[idx_q*CHUNK +: CHUNK] ^ {CHUNK{inv_q}}} + {{CHUNK{1'b0}}, carry_q};
    data_d = data_q;
    data_d[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      idx_q       <= '0;
      inv_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q  <= op_in;
            inv_q   <= neg_in;
            carry_q <= neg_in;
            ovf_q   <= ovf_in;
            idx_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          data_q  <= data_d;
          carry_q <= sum[CHUNK];
          if (idx_q == LastIdx) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_compliment2_iter.sv
// Scoreboard bench for compliment2_iter: an 8/4 instance and a 48/8 instance driven by
// directed vectors, with monitors popping expected results on each output handshake.
module tb_compliment2_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit instance
  logic        rst8 = 1'b1, in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, out_ovf8;
  logic [7:0]  in_data8 = '0, out_data8;
  logic [1:0]  mode8 = '0;
  // 48-bit instance
  logic        rst48 = 1'b1, in_valid48 = 1'b0, in_ready48, out_valid48, out_ready48 = 1'b1;
  logic        out_ovf48;
  logic [47:0] in_data48 = '0, out_data48;
  logic [1:0]  mode48 = '0;

  compliment2_iter #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_ovf(out_ovf8)
  );

  compliment2_iter #(.WIDTH(48), .CHUNK(8)) dut48 (
    .clk(clk), .rst(rst48), .in_valid(in_valid48), .in_ready(in_ready48), .in_data(in_data48),
    .mode(mode48), .out_valid(out_valid48), .out_ready(out_ready48), .out_data(out_data48),
    .out_ovf(out_ovf48)
  );

  logic [48:0] q8[$];
  logic [48:0] q48[$];
  int acc8 = 0, acc48 = 0;
  logic pv8 = 1'b0, pv48 = 1'b0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: latency check on each rising out_valid, scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (rst8) begin
      pv8 <= 1'b0;
    end else begin
      if (out_valid8 && !pv8) check("lat8", 48'(cyc - acc8), 48'd2);
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) check("unexpected8", {47'd0, out_valid8}, 48'd0);
        else begin
          logic [48:0] e;
          e = q8.pop_front();
          check("data8", {40'd0, out_data8}, e[47:0]);
          check("ovf8", {47'd0, out_ovf8}, {47'd0, e[48]});
        end
      end
      pv8 <= out_valid8;
    end
  end

  always @(negedge clk) begin
    if (rst48) begin
      pv48 <= 1'b0;
    end else begin
      if (out_valid48 && !pv48) check("lat48", 48'(cyc - acc48), 48'd6);
      if (out_valid48 && out_ready48) begin
        if (q48.size() == 0) check("unexpected48", {47'd0, out_valid48}, 48'd0);
        else begin
          logic [48:0] e;
          e = q48.pop_front();
          check("data48", out_data48, e[47:0]);
          check("ovf48", {47'd0, out_ovf48}, {47'd0, e[48]});
        end
      end
      pv48 <= out_valid48;
    end
  end

  task automatic issue8(input logic [1:0] m, input logic [7:0] d, input logic [7:0] e,
                        input logic eovf);
    int n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) check("timeout_in_ready8", {47'd0, in_ready8}, 48'd1);
    in_valid8 = 1'b1;
    mode8     = m;
    in_data8  = d;
    q8.push_back({eovf, 40'd0, e});
    @(posedge clk);
    #1;
    acc8      = cyc;
    in_valid8 = 1'b0;
    in_data8  = ~d;      // post-accept changes must not matter
    mode8     = ~m;
  endtask

  task automatic issue48(input logic [1:0] m, input logic [47:0] d, input logic [47:0] e,
                         input logic eovf);
    int n = 0;
    @(negedge clk);
    while (!in_ready48 && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) check("timeout_in_ready48", {47'd0, in_ready48}, 48'd1);
    in_valid48 = 1'b1;
    mode48     = m;
    in_data48  = d;
    q48.push_back({eovf, e});
    @(posedge clk);
    #1;
    acc48      = cyc;
    in_valid48 = 1'b0;
    in_data48  = ~d;
    mode48     = ~m;
  endtask

  initial begin
    #1;
    check("rst_out_valid8", {47'd0, out_valid8}, 48'd0);
    check("rst_out_data8", {40'd0, out_data8}, 48'd0);
    check("rst_in_ready8", {47'd0, in_ready8}, 48'd0);
    check("rst_out_data48", out_data48, 48'd0);
    repeat (2) @(negedge clk);
    rst8  = 1'b0;
    rst48 = 1'b0;
    @(negedge clk);
    check("idle_in_ready8", {47'd0, in_ready8}, 48'd1);

    // Basic vectors, 8-bit
    issue8(2'b01, 8'h05, 8'hFB, 1'b0);
    issue8(2'b01, 8'h80, 8'h80, 1'b1);
    issue8(2'b10, 8'h80, 8'h80, 1'b1);
    issue8(2'b01, 8'h00, 8'h00, 1'b0);
    issue8(2'b10, 8'hF0, 8'h10, 1'b0);
    issue8(2'b10, 8'h10, 8'h10, 1'b0);
    issue8(2'b11, 8'h85, 8'hFB, 1'b0);
    issue8(2'b11, 8'h80, 8'h00, 1'b0);
    issue8(2'b00, 8'hA7, 8'hA7, 1'b0);

    // 48-bit: carry ripple across every chunk, pass-through, most-negative overflow
    issue48(2'b01, 48'h0000_0000_0100, 48'hFFFF_FFFF_FF00, 1'b0);
    issue48(2'b00, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 1'b0);
    issue48(2'b10, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b1);
    issue48(2'b01, 48'h0000_0000_0001, 48'hFFFF_FFFF_FFFF, 1'b0);

    // Back-pressure: hold DONE for 5 cycles, pulse in_valid which must be ignored
    out_ready8 = 1'b0;
    issue8(2'b01, 8'h05, 8'hFB, 1'b0);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid8 && n < 30) begin @(negedge clk); n++; end
      if (n >= 30) check("timeout_out_valid8", {47'd0, out_valid8}, 48'd1);
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid8", {47'd0, out_valid8}, 48'd1);
      check("hold_data8", {40'd0, out_data8}, 48'hFB);
      check("hold_ovf8", {47'd0, out_ovf8}, 48'd0);
      check("hold_in_ready8", {47'd0, in_ready8}, 48'd0);
      in_valid8 = (i == 2);
      in_data8  = 8'h33;
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    @(posedge clk);
    #1;
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_done8", {47'd0, in_ready8}, 48'd1);
    issue8(2'b00, 8'h3C, 8'h3C, 1'b0);

    // Reset in the middle of BUSY (idx=1): result discarded, unit recovers
    issue8(2'b01, 8'h05, 8'hFB, 1'b0);
    @(posedge clk);
    #1;
    rst8 = 1'b1;
    #1;
    check("midrst_out_valid8", {47'd0, out_valid8}, 48'd0);
    check("midrst_out_data8", {40'd0, out_data8}, 48'd0);
    check("midrst_in_ready8", {47'd0, in_ready8}, 48'd0);
    q8.delete();
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    check("postrst_in_ready8", {47'd0, in_ready8}, 48'd1);
    issue8(2'b01, 8'h01, 8'hFF, 1'b0);

    begin
      int n = 0;
      while ((q8.size() != 0 || q48.size() != 0) && n < 100) begin @(negedge clk); n++; end
      check("drain_q8", 48'(q8.size()), 48'd0);
      check("drain_q48", 48'(q48.size()), 48'd0);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
